// File: rtl/wb_bram_burst_pkg.sv
// Shared types for the Wishbone burst BRAM slave: cycle-type and
// burst-type encodings plus the read FSM state.
package wb_pkg;

   typedef enum logic [2:0] {
      CLASSIC = 3'b000,
      CONST   = 3'b001,
      INCR    = 3'b010,
      EOB     = 3'b111
   } cti_t;

   typedef enum logic [1:0] {
      LINEAR = 2'b00,
      WRAP4  = 2'b01,
      WRAP8  = 2'b10,
      WRAP16 = 2'b11
   } bte_t;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_STREAM = 1'b1
   } state_t;

endpackage

// File: rtl/wb_bram_burst_bram_be.sv
// Synchronous single-write / single-read RAM with byte-lane enables.
// The read data register is resettable; the array itself is not, so the
// contents survive a reset. A read and write to the same word on one edge
// returns the old contents.
module bram_be #(
   parameter int DATA_WIDTH    = 32,
   parameter int MEM_ADR_WIDTH = 11
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      wr_en,
   input  logic [MEM_ADR_WIDTH-1:0]  wr_addr,
   input  logic [DATA_WIDTH/8-1:0]   wr_sel,
   input  logic [DATA_WIDTH-1:0]     wr_data,
   input  logic                      rd_en,
   input  logic [MEM_ADR_WIDTH-1:0]  rd_addr,
   output logic [DATA_WIDTH-1:0]     rd_data
);

   localparam int SEL_WIDTH = DATA_WIDTH / 8;
   localparam int DEPTH     = 2 ** MEM_ADR_WIDTH;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rd_data_d;
   logic [DATA_WIDTH-1:0] rd_data_q;

   // Byte-lane write port: only the lanes flagged in wr_sel are updated.
   always_ff @(posedge clk) begin
      for (int b = 0; b < SEL_WIDTH; b++) begin
         if (wr_en && wr_sel[b]) begin
            mem_q[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
         end
      end
   end

   // Next read data: load on a read, otherwise hold the last word.
   always_comb begin
      rd_data_d = rd_data_q;
      if (rd_en) begin
         rd_data_d = mem_q[rd_addr];
      end else begin
         rd_data_d = rd_data_q;
      end
   end

   // Read data register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rd_data_q <= {DATA_WIDTH{1'b0}};
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/wb_bram_burst.sv
// Wishbone B4 registered-feedback block-RAM slave with classic, constant
// and incrementing bursts at one word per clock. Writes are acknowledged
// combinationally; reads go through a two-state FSM with a registered ack.
// Define WB_BRAM_WRAP_EN to let bte select wrap-4/8/16 burst addressing;
// without it every incrementing burst is linear and bte is ignored.
module wb_bram_burst
   import wb_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int MEM_ADR_WIDTH = 11,
   parameter int BUS_ADR_WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      cyc,
   input  logic                      stb,
   input  logic                      we,
   input  logic [BUS_ADR_WIDTH-1:0]  adr,
   input  logic [DATA_WIDTH/8-1:0]   sel,
   input  logic [2:0]                cti,
   input  logic [1:0]                bte,
   input  logic [DATA_WIDTH-1:0]     dat_ms,
   output logic [DATA_WIDTH-1:0]     dat_sm,
   output logic                      ack,
   output logic                      err,
   output logic                      rty
);

   localparam int SEL_WIDTH = DATA_WIDTH / 8;
   localparam int L         = $clog2(SEL_WIDTH);
   localparam int AW        = MEM_ADR_WIDTH;

   localparam logic [AW-1:0]            WORD_ONE = {{(AW-1){1'b0}}, 1'b1};
   localparam logic [AW-1:0]            ALL_ONES = {AW{1'b1}};
   localparam logic [BUS_ADR_WIDTH-1:0] LOW_MASK =
      ({{(BUS_ADR_WIDTH-1){1'b0}}, 1'b1} << L) - {{(BUS_ADR_WIDTH-1){1'b0}}, 1'b1};

   // Advance a word index; only the bits under mask move, the rest hold.
   function automatic logic [AW-1:0] next_word(input logic [AW-1:0] w,
                                                input logic [AW-1:0] mask);
      return (w & ~mask) | ((w + WORD_ONE) & mask);
   endfunction

   state_t          state_d, state_q;
   logic [AW-1:0]   ptr_d, ptr_q;
   logic [AW-1:0]   cur_d, cur_q;
   logic            ack_d, ack_q;
   logic            err_d, err_q;

   logic            req_s;
   logic            oor_s;
   logic [AW-1:0]   word_s;
   logic            rd_req_s;
   logic            wr_ack_s;
   logic            wr_err_s;
   logic            rd_en_s;
   logic [AW-1:0]   rd_addr_s;
   logic [AW-1:0]   wrap_mask_s;
   logic [DATA_WIDTH-1:0] rd_data_s;

   assign req_s    = cyc & stb;
   assign word_s   = adr[AW+L-1:L];
   assign oor_s    = (|(adr >> (AW + L))) | (|(adr & LOW_MASK));
   assign rd_req_s = req_s & ~we;
   assign wr_ack_s = req_s & we & ~oor_s;
   assign wr_err_s = req_s & we & oor_s;

`ifdef WB_BRAM_WRAP_EN
   // Burst wrap mask chosen by bte: the bits that increment within a burst.
   always_comb begin
      wrap_mask_s = ALL_ONES;
      case (bte_t'(bte))
         LINEAR:  wrap_mask_s = ALL_ONES;
         WRAP4:   wrap_mask_s = ~(ALL_ONES << 2);
         WRAP8:   wrap_mask_s = ~(ALL_ONES << 3);
         WRAP16:  wrap_mask_s = ~(ALL_ONES << 4);
         default: wrap_mask_s = ALL_ONES;
      endcase
   end
`else
   logic unused_bte_s;
   assign unused_bte_s = ^bte;
   assign wrap_mask_s  = ALL_ONES;
`endif

   // Read FSM next-state, pointer and registered-response logic.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      cur_d     = cur_q;
      ack_d     = 1'b0;
      err_d     = 1'b0;
      rd_en_s   = 1'b0;
      rd_addr_s = word_s;
      case (state_q)
         ST_IDLE: begin
            if (rd_req_s && !oor_s) begin
               rd_en_s   = 1'b1;
               rd_addr_s = word_s;
               cur_d     = word_s;
               ptr_d     = next_word(word_s, wrap_mask_s);
               ack_d     = 1'b1;
               state_d   = ST_STREAM;
            end else if (rd_req_s && oor_s) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_STREAM: begin
            if (rd_req_s && (cti == INCR)) begin
               rd_en_s   = 1'b1;
               rd_addr_s = ptr_q;
               cur_d     = ptr_q;
               ptr_d     = next_word(ptr_q, wrap_mask_s);
               ack_d     = 1'b1;
               state_d   = ST_STREAM;
            end else if (rd_req_s && (cti == CONST)) begin
               rd_en_s   = 1'b1;
               rd_addr_s = cur_q;
               ack_d     = 1'b1;
               state_d   = ST_STREAM;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM, pointer and response registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         ptr_q   <= {AW{1'b0}};
         cur_q   <= {AW{1'b0}};
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cur_q   <= cur_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
      end
   end

   bram_be #(
      .DATA_WIDTH    (DATA_WIDTH),
      .MEM_ADR_WIDTH (MEM_ADR_WIDTH)
   ) u_ram (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (wr_ack_s),
      .wr_addr (word_s),
      .wr_sel  (sel),
      .wr_data (dat_ms),
      .rd_en   (rd_en_s),
      .rd_addr (rd_addr_s),
      .rd_data (rd_data_s)
   );

   assign dat_sm = rd_data_s;
   assign ack    = ack_q | wr_ack_s;
   assign err    = err_q | wr_err_s;
   assign rty    = 1'b0;

endmodule

// File: tb/tb_wb_bram_burst.sv
// Directed self-checking bench for wb_bram_burst (default parameters).
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_wb_bram_burst;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cyc, stb, we;
   logic [31:0] adr;
   logic [3:0]  sel;
   logic [2:0]  cti;
   logic [1:0]  bte;
   logic [31:0] dat_ms;
   logic [31:0] dat_sm;
   logic        ack, err, rty;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   wb_bram_burst dut (
      .clk     (clk),
      .reset_n (reset_n),
      .cyc     (cyc),
      .stb     (stb),
      .we      (we),
      .adr     (adr),
      .sel     (sel),
      .cti     (cti),
      .bte     (bte),
      .dat_ms  (dat_ms),
      .dat_sm  (dat_sm),
      .ack     (ack),
      .err     (err),
      .rty     (rty)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic s, input logic w, input logic [31:0] a,
                        input logic [3:0] sl, input logic [2:0] ct,
                        input logic [1:0] bt, input logic [31:0] d);
      @(negedge clk);
      cyc = s; stb = s; we = w; adr = a; sel = sl; cti = ct; bte = bt; dat_ms = d;
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 32'h0, 4'h0, 3'b000, 2'b00, 32'h0);
   endtask

   task automatic wr(input logic [31:0] a, input logic [3:0] sl, input logic [31:0] d);
      drive(1'b1, 1'b1, a, sl, 3'b000, 2'b00, d);
      chk("wr_ack", {31'h0, ack}, 32'h1);
   endtask

   task automatic classic_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
      drive(1'b1, 1'b0, a, 4'hF, 3'b000, 2'b00, 32'h0);
      chk({tag, "_ack_n"}, {31'h0, ack}, 32'h0);
      idle();
      chk({tag, "_ack"}, {31'h0, ack}, 32'h1);
      chk({tag, "_dat"}, dat_sm, exp);
      idle();
      chk({tag, "_ackfall"}, {31'h0, ack}, 32'h0);
   endtask

   initial begin
      reset_n = 1'b0;
      cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 32'h0; sel = 4'h0;
      cti = 3'b000; bte = 2'b00; dat_ms = 32'h0;

      // Reset state
      idle();
      idle();
      chk("rst_ack", {31'h0, ack}, 32'h0);
      chk("rst_err", {31'h0, err}, 32'h0);
      chk("rst_rty", {31'h0, rty}, 32'h0);
      chk("rst_dat", dat_sm, 32'h0);
      reset_n = 1'b1;
      idle();

      // Byte-lane write then classic read
      wr(32'h10, 4'hF, 32'hAABBCCDD);
      wr(32'h10, 4'h1, 32'h00000011);
      idle();
      classic_rd("be_rd", 32'h10, 32'hAABBCC11);

      // Preload words 0..7 with their index, word 2047 with a marker
      for (int i = 0; i < 8; i++) wr(32'(i * 4), 4'hF, 32'(i));
      wr(32'h1FFC, 4'hF, 32'hDEAD2047);
      idle();

      // Incrementing burst of 8 beats from 0x0
      drive(1'b1, 1'b0, 32'h0, 4'hF, 3'b010, 2'b00, 32'h0);
      for (int j = 1; j <= 8; j++) begin
         drive(1'b1, 1'b0, 32'((j - 1) * 4), 4'hF, (j == 8) ? 3'b111 : 3'b010, 2'b00, 32'h0);
         chk($sformatf("incr_ack%0d", j - 1), {31'h0, ack}, 32'h1);
         chk($sformatf("incr_dat%0d", j - 1), dat_sm, 32'(j - 1));
      end
      idle();
      chk("incr_end_ack", {31'h0, ack}, 32'h0);

      // Burst across the top of memory
      drive(1'b1, 1'b0, 32'h1FFC, 4'hF, 3'b010, 2'b00, 32'h0);
      drive(1'b1, 1'b0, 32'h1FFC, 4'hF, 3'b010, 2'b00, 32'h0);
      chk("top_dat0", dat_sm, 32'hDEAD2047);
      drive(1'b1, 1'b0, 32'h0, 4'hF, 3'b111, 2'b00, 32'h0);
      chk("top_ack1", {31'h0, ack}, 32'h1);
      chk("top_dat1", dat_sm, 32'h0);
      idle();
      chk("top_end_ack", {31'h0, ack}, 32'h0);

      // Out-of-range read: registered err pulse, no ack
      drive(1'b1, 1'b0, 32'h2000, 4'hF, 3'b000, 2'b00, 32'h0);
      chk("oor_rd_err0", {31'h0, err}, 32'h0);
      idle();
      chk("oor_rd_err1", {31'h0, err}, 32'h1);
      chk("oor_rd_ack1", {31'h0, ack}, 32'h0);
      idle();
      chk("oor_rd_err2", {31'h0, err}, 32'h0);

      // Misaligned read is also out of range
      drive(1'b1, 1'b0, 32'h12, 4'hF, 3'b000, 2'b00, 32'h0);
      idle();
      chk("mis_rd_err", {31'h0, err}, 32'h1);
      chk("mis_rd_ack", {31'h0, ack}, 32'h0);
      idle();

      // Out-of-range write: combinational err, memory untouched
      drive(1'b1, 1'b1, 32'h2000, 4'hF, 3'b000, 2'b00, 32'h12345678);
      chk("oor_wr_err", {31'h0, err}, 32'h1);
      chk("oor_wr_ack", {31'h0, ack}, 32'h0);
      idle();
      chk("oor_wr_err_fall", {31'h0, err}, 32'h0);
      classic_rd("oor_wr_chk", 32'h0, 32'h0);

      // Constant burst on word 3
      drive(1'b1, 1'b0, 32'hC, 4'hF, 3'b001, 2'b00, 32'h0);
      drive(1'b1, 1'b0, 32'hC, 4'hF, 3'b001, 2'b00, 32'h0);
      chk("const_dat0", dat_sm, 32'h3);
      drive(1'b1, 1'b0, 32'hC, 4'hF, 3'b111, 2'b00, 32'h0);
      chk("const_ack1", {31'h0, ack}, 32'h1);
      chk("const_dat1", dat_sm, 32'h3);
      idle();
      chk("const_end_ack", {31'h0, ack}, 32'h0);

      // Master wait state inside a burst, then resume at current adr
      drive(1'b1, 1'b0, 32'h4, 4'hF, 3'b010, 2'b00, 32'h0);
      idle();
      chk("ws_ack0", {31'h0, ack}, 32'h1);
      chk("ws_dat0", dat_sm, 32'h1);
      drive(1'b1, 1'b0, 32'h8, 4'hF, 3'b010, 2'b00, 32'h0);
      chk("ws_gap_ack", {31'h0, ack}, 32'h0);
      drive(1'b1, 1'b0, 32'h8, 4'hF, 3'b111, 2'b00, 32'h0);
      chk("ws_ack1", {31'h0, ack}, 32'h1);
      chk("ws_dat1", dat_sm, 32'h2);
      idle();
      chk("ws_end_ack", {31'h0, ack}, 32'h0);

`ifdef WB_BRAM_WRAP_EN
      // Wrap-4 burst from word 6: 6, 7, 4, 5
      drive(1'b1, 1'b0, 32'h18, 4'hF, 3'b010, 2'b01, 32'h0);
      for (int j = 0; j < 4; j++) begin
         drive(1'b1, 1'b0, 32'h18, 4'hF, (j == 3) ? 3'b111 : 3'b010, 2'b01, 32'h0);
         chk($sformatf("wrap4_dat%0d", j), dat_sm, (j < 2) ? 32'(6 + j) : 32'(2 + j));
      end
      idle();
      chk("wrap4_end_ack", {31'h0, ack}, 32'h0);
`endif

      // Reset held 3 cycles mid-burst; memory preserved
      drive(1'b1, 1'b0, 32'h14, 4'hF, 3'b010, 2'b00, 32'h0);
      drive(1'b1, 1'b0, 32'h14, 4'hF, 3'b010, 2'b00, 32'h0);
      chk("mid_ack", {31'h0, ack}, 32'h1);
      chk("mid_dat", dat_sm, 32'h5);
      reset_n = 1'b0;
      for (int j = 0; j < 2; j++) begin
         drive(1'b1, 1'b0, 32'h18, 4'hF, 3'b010, 2'b00, 32'h0);
         chk($sformatf("mrst_ack%0d", j), {31'h0, ack}, 32'h0);
         chk($sformatf("mrst_dat%0d", j), dat_sm, 32'h0);
      end
      idle();
      chk("mrst_ack2", {31'h0, ack}, 32'h0);
      chk("mrst_err2", {31'h0, err}, 32'h0);
      chk("mrst_dat2", dat_sm, 32'h0);
      reset_n = 1'b1;
      idle();
      classic_rd("post_rst", 32'h14, 32'h5);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
